// File: rtl/item_select_arb.sv
// item_select_arb: round-robin arbiter over NUM_CH item-selection sources
// feeding a FIFO_DEPTH-entry queue toward the dispense controller.
// Optional feature macro: ITEM_SELECT_RANGE_CHECK_EN (drop addresses > MAX_ITEM).
module item_select_arb #(
    parameter int unsigned ITEM_ADDR_WIDTH = 10,
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_ITEM        = 1023
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CH*ITEM_ADDR_WIDTH-1:0] sel_addr,
    input  logic [NUM_CH-1:0]                 sel_valid,
    output logic [NUM_CH-1:0]                 sel_ready,
    output logic [NUM_CH-1:0]                 sel_reject,
    output logic [ITEM_ADDR_WIDTH-1:0]        out_item,
    output logic [$clog2(NUM_CH)-1:0]         out_ch,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ITEM_ADDR_WIDTH-1:0] mem_item [FIFO_DEPTH];
    logic [CH_W-1:0]            mem_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [CNT_W-1:0]           count;
    logic [CH_W-1:0]            rr_ptr;

    logic                       grant_found;
    logic [CH_W-1:0]            grant_idx;
    logic [ITEM_ADDR_WIDTH-1:0] grant_addr;
    logic                       hs;
    logic                       in_range;
    logic                       push;
    logic                       pop;
    logic [PTR_W-1:0]           rd_next;
    logic [CNT_W-1:0]           count_next;
    logic [ITEM_ADDR_WIDTH-1:0] head_item_next;
    logic [CH_W-1:0]            head_ch_next;
    logic [CH_W-1:0]            rr_next;

    // Round-robin search upward from rr_ptr; grant gated by registered occupancy.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_ready   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_found && sel_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
        if (!rst && grant_found && (count < CNT_W'(FIFO_DEPTH))) begin
            sel_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_addr = sel_addr[grant_idx*ITEM_ADDR_WIDTH +: ITEM_ADDR_WIDTH];
    assign hs         = |(sel_valid & sel_ready);
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_count = count;

`ifdef ITEM_SELECT_RANGE_CHECK_EN
    assign in_range = (32'(grant_addr) <= MAX_ITEM);
`else
    logic unused_max_item;
    assign in_range        = 1'b1;
    assign unused_max_item = ^32'(MAX_ITEM);
`endif

    assign push = hs && in_range;

    // Next-state for pointers, occupancy and the registered head view.
    always_comb begin
        rd_next        = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next     = count;
        head_item_next = mem_item[rd_next];
        head_ch_next   = mem_ch[rd_next];
        rr_next        = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        // Entry written this edge becomes the head when the queue drains to it.
        if (push && (wr_ptr == rd_next)) begin
            head_item_next = grant_addr;
            head_ch_next   = grant_idx;
        end
    end

    // Queue storage, pointers, RR pointer and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rr_ptr   <= '0;
            out_item <= '0;
            out_ch   <= '0;
        end else begin
            if (push) begin
                mem_item[wr_ptr] <= grant_addr;
                mem_ch[wr_ptr]   <= grant_idx;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (hs) rr_ptr <= rr_next;
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0) begin
                out_item <= head_item_next;
                out_ch   <= head_ch_next;
            end
        end
    end

`ifdef ITEM_SELECT_RANGE_CHECK_EN
    // One-cycle reject pulse for a consumed out-of-range address.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reject <= '0;
        end else begin
            sel_reject <= (hs && !in_range) ? sel_ready : '0;
        end
    end
`else
    assign sel_reject = '0;
`endif

endmodule
